// File: rtl/link_sta_pkg.sv
// Shared definitions for the 10G link statistics collector: default geometry,
// counter index map and snapshot FSM encoding.
package link_sta_pkg;

    localparam int unsigned STA_NUM_CNT    = 32'd16;
    localparam int unsigned STA_ADDR_WIDTH = 32'd4;
    localparam int unsigned STA_CNT_WIDTH  = 32'd64;

    localparam int unsigned STA_RX_FRM       = 32'd0;
    localparam int unsigned STA_TX_FRM       = 32'd1;
    localparam int unsigned STA_RX_CRC_ERR   = 32'd2;
    localparam int unsigned STA_RX_LANE_ERR  = 32'd3;
    localparam int unsigned STA_RX_ALIGN_ERR = 32'd4;
    localparam int unsigned STA_TX_UNDERRUN  = 32'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WALK = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/link_sta_timer.sv
// Free-running period counter for automatic snapshots. tc is high for the
// single cycle in which the count sits at PERIOD_CYC-1; PERIOD_CYC=0 disables it.
module link_sta_timer #(
    parameter int unsigned PERIOD_CYC = 32'd156_250_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tc
);

    generate
        if (PERIOD_CYC == 32'd0) begin : g_off
            assign tc = 1'b0;
        end else begin : g_on
            localparam int unsigned TW = (PERIOD_CYC > 32'd1) ? $clog2(PERIOD_CYC) : 32'd1;
            localparam logic [TW-1:0] LAST = TW'(PERIOD_CYC - 32'd1);

            logic [TW-1:0] cnt_r;

            // Period counter, wraps at terminal count regardless of snapshot requests
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_r <= '0;
                end else if (cnt_r == LAST) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + TW'(1);
                end
            end

            assign tc = (cnt_r == LAST);
        end
    endgenerate

endmodule

// File: rtl/link_sta_collector.sv
// Link event counters with a snapshot walker that copies every counter, in
// index order, into the statistics mirror RAM on request or on the period timer.
module link_sta_collector
    import link_sta_pkg::*;
#(
    parameter int unsigned NUM_CNT     = STA_NUM_CNT,
    parameter int unsigned ADDR_WIDTH  = STA_ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH   = STA_CNT_WIDTH,
    parameter int unsigned PERIOD_CYC  = 32'd156_250_000,
    parameter int unsigned CLR_ON_SNAP = 32'd0,
    parameter int unsigned SATURATE    = 32'd1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CNT-1:0]    evt,
    input  logic                  cnt_clr,
    input  logic                  snap_req,
    output logic                  snap_busy,
    output logic                  snap_done,
    output logic                  sta_wr_en,
    output logic [ADDR_WIDTH-1:0] sta_wr_addr,
    output logic [CNT_WIDTH-1:0]  sta_wr_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_CNT - 32'd1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  cnt_r     [NUM_CNT];
    logic [CNT_WIDTH-1:0]  cnt_nxt_s [NUM_CNT];
    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [ADDR_WIDTH-1:0] idx_r;
    logic [ADDR_WIDTH-1:0] idx_nxt_s;
    logic                  pending_r;
    logic                  pending_nxt_s;
    logic                  tc_s;
    logic                  trig_s;
    logic [CNT_WIDTH-1:0]  wr_data_nxt_s;

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if ((SATURATE != 32'd0) && (v == CNT_MAX)) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    link_sta_timer #(
        .PERIOD_CYC (PERIOD_CYC)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tc    (tc_s)
    );

    assign trig_s = snap_req | tc_s;

    // Counter update: clear beats snapshot-restart beats increment
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (cnt_clr) begin
                cnt_nxt_s[i] = '0;
            end else if ((CLR_ON_SNAP != 32'd0) && (state_r == ST_WALK) &&
                         (idx_r == ADDR_WIDTH'(i))) begin
                cnt_nxt_s[i] = evt[i] ? CNT_ONE : '0;
            end else if (evt[i]) begin
                cnt_nxt_s[i] = cnt_inc(cnt_r[i]);
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Snapshot FSM next state; triggers during a walk coalesce into one pending rerun
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        pending_nxt_s = pending_r;
        case (state_r)
            ST_IDLE: begin
                pending_nxt_s = 1'b0;
                idx_nxt_s     = '0;
                if (trig_s) begin
                    state_nxt_s = ST_WALK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WALK: begin
                pending_nxt_s = pending_r | trig_s;
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_DONE;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_WALK;
                    idx_nxt_s   = idx_r + ADDR_WIDTH'(1);
                end
            end
            ST_DONE: begin
                pending_nxt_s = 1'b0;
                idx_nxt_s     = '0;
                if (pending_r || trig_s) begin
                    state_nxt_s = ST_WALK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                idx_nxt_s     = '0;
                pending_nxt_s = 1'b0;
            end
        endcase
    end

    // Write-data select from next counter values so the registered output
    // shows the entry as it stood before the write cycle's own update
    always_comb begin
        wr_data_nxt_s = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            wr_data_nxt_s = (idx_nxt_s == ADDR_WIDTH'(i)) ? cnt_nxt_s[i] : wr_data_nxt_s;
        end
    end

    // Counter array storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // FSM state and registered outputs, all loaded from the same next-state view
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            pending_r   <= 1'b0;
            snap_busy   <= 1'b0;
            snap_done   <= 1'b0;
            sta_wr_en   <= 1'b0;
            sta_wr_addr <= '0;
            sta_wr_data <= '0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            pending_r   <= pending_nxt_s;
            snap_busy   <= (state_nxt_s != ST_IDLE);
            snap_done   <= (state_nxt_s == ST_DONE);
            sta_wr_en   <= (state_nxt_s == ST_WALK);
            sta_wr_addr <= (state_nxt_s == ST_WALK) ? idx_nxt_s : '0;
            sta_wr_data <= (state_nxt_s == ST_WALK) ? wr_data_nxt_s : '0;
        end
    end

endmodule

// File: tb/tb_link_sta_collector.sv
// Directed bench for link_sta_collector: default build plus narrow saturating,
// wrapping, clear-on-snapshot and short-period builds.
module tb_link_sta_collector;
    import link_sta_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // default build
    logic        rst_main_n;
    logic [15:0] evt_m;
    logic        clr_m, snap_m;
    logic        busy_m, done_m, wen_m;
    logic [3:0]  addr_m;
    logic [63:0] data_m;

    // 8-bit saturating / wrapping builds share stimulus
    logic        rst_aux_n;
    logic [15:0] evt_a;
    logic        snap_a;
    logic        busy_s, done_s, wen_s, busy_w, done_w, wen_w;
    logic [3:0]  addr_s, addr_w;
    logic [7:0]  data_s, data_w;

    // clear-on-snapshot build
    logic [15:0] evt_c;
    logic        snap_c;
    logic        busy_c, done_c, wen_c;
    logic [3:0]  addr_c;
    logic [63:0] data_c;

    // short-period build
    logic        rst_per_n;
    logic        snap_p;
    logic        busy_p, done_p, wen_p;
    logic [3:0]  addr_p;
    logic [63:0] data_p;

    link_sta_collector u_main (
        .clk(clk), .rst_n(rst_main_n), .evt(evt_m), .cnt_clr(clr_m), .snap_req(snap_m),
        .snap_busy(busy_m), .snap_done(done_m), .sta_wr_en(wen_m),
        .sta_wr_addr(addr_m), .sta_wr_data(data_m)
    );

    link_sta_collector #(.CNT_WIDTH(8), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_aux_n), .evt(evt_a), .cnt_clr(1'b0), .snap_req(snap_a),
        .snap_busy(busy_s), .snap_done(done_s), .sta_wr_en(wen_s),
        .sta_wr_addr(addr_s), .sta_wr_data(data_s)
    );

    link_sta_collector #(.CNT_WIDTH(8), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_aux_n), .evt(evt_a), .cnt_clr(1'b0), .snap_req(snap_a),
        .snap_busy(busy_w), .snap_done(done_w), .sta_wr_en(wen_w),
        .sta_wr_addr(addr_w), .sta_wr_data(data_w)
    );

    link_sta_collector #(.CLR_ON_SNAP(1)) u_cos (
        .clk(clk), .rst_n(rst_aux_n), .evt(evt_c), .cnt_clr(1'b0), .snap_req(snap_c),
        .snap_busy(busy_c), .snap_done(done_c), .sta_wr_en(wen_c),
        .sta_wr_addr(addr_c), .sta_wr_data(data_c)
    );

    link_sta_collector #(.PERIOD_CYC(100)) u_per (
        .clk(clk), .rst_n(rst_per_n), .evt(16'h0000), .cnt_clr(1'b0), .snap_req(snap_p),
        .snap_busy(busy_p), .snap_done(done_p), .sta_wr_en(wen_p),
        .sta_wr_addr(addr_p), .sta_wr_data(data_p)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          ev_total;
    logic [63:0] e1, e2, e3;
    logic [63:0] d1 [16];
    logic [63:0] sum2;
    int          nwr, nd, start2, nst;
    int          done_at [4];
    int          starts [8];

    task automatic cos_step();
        if (evt_c[0]) ev_total++;
        step();
    endtask

    initial begin
        rst_main_n = 1'b0; rst_aux_n = 1'b0; rst_per_n = 1'b0;
        evt_m = '0; clr_m = 1'b0; snap_m = 1'b0;
        evt_a = '0; snap_a = 1'b0; evt_c = '0; snap_c = 1'b0; snap_p = 1'b0;
        repeat (3) step();

        chk("rst_wr_en", {63'd0, wen_m}, 64'd0);
        chk("rst_busy", {63'd0, busy_m}, 64'd0);
        chk("rst_done", {63'd0, done_m}, 64'd0);
        chk("rst_addr", {60'd0, addr_m}, 64'd0);
        chk("rst_data", data_m, 64'd0);

        rst_main_n = 1'b1; rst_aux_n = 1'b1;
        step();

        // Test 1: five events on counter 3, one snapshot
        evt_m[STA_RX_LANE_ERR] = 1'b1;
        repeat (5) step();
        evt_m = '0;
        snap_m = 1'b1;
        step();
        snap_m = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("t1_wen_%0d", k), {63'd0, wen_m}, 64'd1);
            chk($sformatf("t1_addr_%0d", k), {60'd0, addr_m}, 64'(k));
            chk($sformatf("t1_data_%0d", k), data_m, (k == 3) ? 64'd5 : 64'd0);
            chk($sformatf("t1_done_%0d", k), {63'd0, done_m}, 64'd0);
            step();
        end
        chk("t1_done", {63'd0, done_m}, 64'd1);
        chk("t1_done_busy", {63'd0, busy_m}, 64'd1);
        chk("t1_done_wen", {63'd0, wen_m}, 64'd0);
        step();
        chk("t1_idle_done", {63'd0, done_m}, 64'd0);
        chk("t1_idle_busy", {63'd0, busy_m}, 64'd0);

        // Test 4 (+ clear priority and clear mid-walk)
        clr_m = 1'b1; evt_m = 16'hFFFF;
        step();
        clr_m = 1'b0;
        repeat (3) step();
        evt_m = '0;
        snap_m = 1'b1;
        step();
        snap_m = 1'b0;
        nwr = 0; nd = 0; start2 = -1; sum2 = 64'd0;
        for (int i = 0; i < 16; i++) d1[i] = 64'hDEAD;
        for (int c = 0; c < 40; c++) begin
            if (done_m) begin
                if (nd < 4) done_at[nd] = c;
                nd++;
            end
            if (wen_m) begin
                nwr++;
                if (nd == 0) d1[addr_m] = data_m;
                else sum2 += data_m;
                if (addr_m == 4'd0 && c > 0 && start2 < 0) start2 = c;
            end
            snap_m = (c == 2 || c == 5);
            clr_m  = (c == 5);
            step();
        end
        snap_m = 1'b0; clr_m = 1'b0;
        chk("t4_writes", 64'(nwr), 64'd32);
        chk("t4_dones", 64'(nd), 64'd2);
        chk("t4_done1_at", 64'(done_at[0]), 64'd16);
        chk("t4_walk2_at", 64'(start2), 64'd17);
        chk("t4_done2_at", 64'(done_at[1]), 64'd33);
        chk("t4_clr_prio_e0", d1[0], 64'd3);
        chk("t4_clr_prio_e3", d1[3], 64'd3);
        chk("t4_pre_clr_e5", d1[5], 64'd3);
        chk("t4_post_clr_e6", d1[6], 64'd0);
        chk("t4_post_clr_e15", d1[15], 64'd0);
        chk("t4_walk2_sum", sum2, 64'd0);

        // Test 6: reset in walk cycle 7
        evt_m = 16'hFFFF;
        repeat (2) step();
        evt_m = '0;
        snap_m = 1'b1;
        step();
        snap_m = 1'b0;
        chk("t6_walk_e0", data_m, 64'd2);
        repeat (7) step();
        chk("t6_addr7", {60'd0, addr_m}, 64'd7);
        rst_main_n = 1'b0;
        #1;
        chk("t6_rst_wen", {63'd0, wen_m}, 64'd0);
        chk("t6_rst_busy", {63'd0, busy_m}, 64'd0);
        chk("t6_rst_addr", {60'd0, addr_m}, 64'd0);
        chk("t6_rst_data", data_m, 64'd0);
        repeat (3) step();
        rst_main_n = 1'b1;
        nwr = 0;
        for (int c = 0; c < 40; c++) begin
            if (wen_m || busy_m || done_m) nwr++;
            step();
        end
        chk("t6_quiet", 64'(nwr), 64'd0);
        snap_m = 1'b1;
        step();
        snap_m = 1'b0;
        chk("t6_new_wen", {63'd0, wen_m}, 64'd1);
        chk("t6_new_data", data_m, 64'd0);
        repeat (18) step();

        // Test 2: 300 events on an 8-bit counter, saturating vs wrapping
        evt_a[STA_RX_FRM] = 1'b1;
        repeat (300) step();
        evt_a = '0;
        snap_a = 1'b1;
        step();
        snap_a = 1'b0;
        chk("t2_sat_wen", {63'd0, wen_s}, 64'd1);
        chk("t2_sat_e0", {56'd0, data_s}, 64'd255);
        chk("t2_wrap_e0", {56'd0, data_w}, 64'd44);
        step();
        chk("t2_sat_e1", {56'd0, data_s}, 64'd0);
        repeat (17) step();

        // Test 3: clear-on-snapshot loses no events
        ev_total = 0;
        evt_c[STA_RX_FRM] = 1'b1;
        repeat (10) cos_step();
        snap_c = 1'b1;
        cos_step();
        snap_c = 1'b0;
        chk("t3_wen1", {60'd0, wen_c, addr_c}, 64'h10);
        e1 = data_c;
        repeat (29) cos_step();
        snap_c = 1'b1;
        cos_step();
        snap_c = 1'b0;
        e2 = data_c;
        repeat (5) cos_step();
        evt_c = '0;
        repeat (20) cos_step();
        snap_c = 1'b1;
        cos_step();
        snap_c = 1'b0;
        e3 = data_c;
        chk("t3_e1", e1, 64'd11);
        chk("t3_e2", e2, 64'd30);
        chk("t3_resid", e3, 64'd5);
        chk("t3_total", e1 + e2 + e3, 64'(ev_total));
        chk("t3_total_abs", 64'(ev_total), 64'd46);
        repeat (18) step();

        // Test 5: periodic walks, one cycle numbered 1 right after release
        rst_per_n = 1'b1;
        nst = 0;
        for (int c = 1; c <= 320; c++) begin
            if (wen_p && addr_p == 4'd0) begin
                if (nst < 8) starts[nst] = c;
                nst++;
            end
            snap_p = (c == 150);
            step();
        end
        snap_p = 1'b0;
        chk("t5_nwalks", 64'(nst), 64'd4);
        chk("t5_walk_a", 64'(starts[0]), 64'd101);
        chk("t5_walk_b", 64'(starts[1]), 64'd151);
        chk("t5_walk_c", 64'(starts[2]), 64'd201);
        chk("t5_walk_d", 64'(starts[3]), 64'd301);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
